mp_coeff_loader: RTL and testbench
==================================

# mp_coeff_loader

Initiator-side coefficient loader for the memory-polynomial DPD coefficient BRAM port. It accepts a valid/ready stream of 32-bit coefficient words and drives the MP_BRAM write interface (data, byte address, enable), filling all LUTs in order. It runs in the AXI clock domain between the host/DMA coefficient source and the MP LUT top. It flags framing errors and requests DPD bypass while a load is in progress.

## Interface
Parameters:
- M, 10, memory depth; LUT_NUM = M+1 LUTs
- RESOLUTION, 4096, entries per LUT (power of two)
- Derived: ADDR_W = $clog2(RESOLUTION) + $clog2(M+1) + 2; TOTAL = (M+1)*RESOLUTION words

Ports:
- AXI_clk_i  in  1  sole clock
- reset_n_i  in  1  synchronous, active-low reset
- start_i  in  1  begin a load; sampled only in IDLE
- abort_i  in  1  terminate the load in progress
- s_data_i  in  32  coefficient word {Q[15:0], I[15:0]}
- s_valid_i  in  1  stream valid
- s_last_i  in  1  marks the final word of the frame
- s_ready_o  out  1  stream ready
- coeff_o  out  32  BRAM write data
- coeff_addr_o  out  ADDR_W  BRAM byte address
- coeff_en_o  out  1  BRAM write enable, one cycle per word
- busy_o  out  1  load in progress
- bypass_o  out  1  request DPD bypass while BRAM contents are inconsistent
- done_o  out  1  one-cycle pulse on a clean completion
- error_o  out  1  sticky framing or abort error; cleared by the next start
- checksum_o  out  32  running sum of written words (see Configuration)

## Operation
- State machine: IDLE, LOAD, DONE.
- IDLE:
  - s_ready_o=0.
  - start_i=1 → LOAD; word counter k=0; error_o cleared; checksum cleared.
- LOAD:
  - s_ready_o=1; a word is accepted when s_valid_i & s_ready_o.
  - Each accepted word k is written to coeff_addr_o = 4*k, i.e. {lut index, entry index, 2'b00} with the entry field in the LSBs. This gives LUT l, entry e at byte address 4*(l*RESOLUTION+e).
  - k == TOTAL-1 with s_last_i=1: word written → DONE.
  - k == TOTAL-1 with s_last_i=0: word written; error_o=1 → IDLE; no done.
  - s_last_i=1 with k < TOTAL-1 (early last): word written; error_o=1 → IDLE.
  - abort_i=1 → IDLE; error_o=1. Abort has priority over a same-cycle handshake, and that word is discarded (no coeff_en_o).
- DONE: done_o=1 for one cycle → IDLE.
- busy_o=1 in LOAD and DONE.
- bypass_o is set on the start transition. It stays 1 through LOAD and after any error or abort, and clears only in the DONE cycle. After an error, DPD stays bypassed until a clean reload completes.
- start_i outside IDLE: ignored.
- Counter k is $clog2(TOTAL) bits and never wraps; the terminal count ends the frame.

## Timing
- coeff_o, coeff_addr_o and coeff_en_o are registered: the BRAM write occurs the cycle after the handshake (latency 1).
- Back-to-back handshakes give back-to-back writes at full rate, one word per clock.
- s_ready_o is a decode of the state register, with no combinational path from s_valid_i.
- done_o is asserted 1 cycle after the final handshake, in the same cycle as that word's coeff_en_o. State returns to IDLE the following cycle.
- Reset values (reset_n_i=0 at a clock edge):
  - state=IDLE, k=0.
  - s_ready_o, coeff_en_o, busy_o, done_o and error_o are 0.
  - coeff_o, coeff_addr_o and checksum_o are 0.
  - bypass_o=1, so DPD is off until the first clean load.
- Reset mid-load aborts immediately. A write registered in the same cycle is suppressed (coeff_en_o=0 out of reset).

## Configuration
- MP_COEFF_CHECKSUM_EN defined:
  - checksum_o = modulo-2^32 sum of all words written since the last start.
  - The sum is updated with the same latency as coeff_en_o.
  - It holds its value after DONE or an error until the next start.
- MP_COEFF_CHECKSUM_EN undefined: checksum_o is tied to 0 and no adder is instantiated.

## Test plan
The bench uses M=1, RESOLUTION=4 (TOTAL=8, ADDR_W=5).
- Clean load: start, then words 0x00010000+k with s_last on k=7, valid held high → 8 consecutive coeff_en_o pulses at addresses 0,4,…,28 with data matching. done_o pulses once, bypass_o drops, error_o=0. With the macro defined, checksum_o=0x0008001C.
- Throttled valid (alternating 1/0) → same 8 writes, no duplicates or gaps in address, done_o after the 8th.
- Early last on k=3 → 4 writes (addresses 0–12), error_o=1, no done_o, bypass_o=1, s_ready_o=0 afterwards.
- Missing last on k=7 → 8 writes, error_o=1, no done_o. A following start clears error_o.
- abort_i asserted with a valid word at k=5 → only 5 writes (addresses 0–16), error_o=1, IDLE next cycle.
- reset_n_i low for 1 cycle at k=4, then a new start → all outputs at reset values, then a clean load writes from address 0.

Source files
------------

// File: rtl/mp_coeff_loader.sv
// Streams 32-bit coefficient words into the memory-polynomial LUT BRAM port, one word per clock.
// Optional MP_COEFF_CHECKSUM_EN adds a running modulo-2^32 checksum of written words.
module mp_coeff_loader #(
  parameter  int unsigned M          = 10,
  parameter  int unsigned RESOLUTION = 4096,
  localparam int unsigned ADDR_W     = $clog2(RESOLUTION) + $clog2(M + 1) + 2
) (
  input  logic              AXI_clk_i,
  input  logic              reset_n_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [31:0]       s_data_i,
  input  logic              s_valid_i,
  input  logic              s_last_i,
  output logic              s_ready_o,
  output logic [31:0]       coeff_o,
  output logic [ADDR_W-1:0] coeff_addr_o,
  output logic              coeff_en_o,
  output logic              busy_o,
  output logic              bypass_o,
  output logic              done_o,
  output logic              error_o,
  output logic [31:0]       checksum_o
);

  localparam int unsigned TOTAL = (M + 1) * RESOLUTION;
  localparam int unsigned K_W   = (TOTAL > 1) ? $clog2(TOTAL) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [K_W-1:0]    k;
  logic [K_W-1:0]    k_nxt;
  logic              en_nxt;
  logic [31:0]       data_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic              done_nxt;
  logic              err_nxt;
  logic              byp_nxt;

  // Next-state and next-output decode; the word address is simply 4*k.
  always_comb begin
    state_nxt = state;
    k_nxt     = k;
    en_nxt    = 1'b0;
    data_nxt  = coeff_o;
    addr_nxt  = coeff_addr_o;
    done_nxt  = 1'b0;
    err_nxt   = error_o;
    byp_nxt   = bypass_o;
    case (state)
      S_IDLE: begin
        if (start_i) begin
          state_nxt = S_LOAD;
          k_nxt     = '0;
          err_nxt   = 1'b0;
          byp_nxt   = 1'b1;
        end
      end
      S_LOAD: begin
        if (abort_i) begin
          // Abort wins over a same-cycle handshake; that word is dropped.
          state_nxt = S_IDLE;
          err_nxt   = 1'b1;
        end else if (s_valid_i && s_ready_o) begin
          en_nxt   = 1'b1;
          data_nxt = s_data_i;
          addr_nxt = ADDR_W'({k, 2'b00});
          if (k == K_W'(TOTAL - 1)) begin
            if (s_last_i) begin
              state_nxt = S_DONE;
              done_nxt  = 1'b1;
              byp_nxt   = 1'b0;
            end else begin
              state_nxt = S_IDLE;
              err_nxt   = 1'b1;
            end
          end else if (s_last_i) begin
            state_nxt = S_IDLE;
            err_nxt   = 1'b1;
          end else begin
            k_nxt = k + K_W'(1);
          end
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State register with all status/write outputs registered alongside it.
  always_ff @(posedge AXI_clk_i) begin
    if (!reset_n_i) begin
      state        <= S_IDLE;
      k            <= '0;
      s_ready_o    <= 1'b0;
      coeff_o      <= '0;
      coeff_addr_o <= '0;
      coeff_en_o   <= 1'b0;
      busy_o       <= 1'b0;
      bypass_o     <= 1'b1;
      done_o       <= 1'b0;
      error_o      <= 1'b0;
    end else begin
      state        <= state_nxt;
      k            <= k_nxt;
      s_ready_o    <= (state_nxt == S_LOAD);
      coeff_o      <= data_nxt;
      coeff_addr_o <= addr_nxt;
      coeff_en_o   <= en_nxt;
      busy_o       <= (state_nxt != S_IDLE);
      bypass_o     <= byp_nxt;
      done_o       <= done_nxt;
      error_o      <= err_nxt;
    end
  end

`ifdef MP_COEFF_CHECKSUM_EN
  logic accept;
  logic launch;

  assign accept = (state == S_LOAD) && !abort_i && s_valid_i && s_ready_o;
  assign launch = (state == S_IDLE) && start_i;

  // Checksum tracks the registered writes and holds until the next start.
  always_ff @(posedge AXI_clk_i) begin
    if (!reset_n_i) begin
      checksum_o <= '0;
    end else if (launch) begin
      checksum_o <= '0;
    end else if (accept) begin
      checksum_o <= checksum_o + s_data_i;
    end
  end
`else
  assign checksum_o = '0;
`endif

endmodule

// File: tb/tb_mp_coeff_loader.sv
// Randomized self-checking bench for mp_coeff_loader (M=1, RESOLUTION=4: 8 words, 5-bit byte address).
module tb_mp_coeff_loader;

  localparam int unsigned M      = 1;
  localparam int unsigned RES    = 4;
  localparam int unsigned TOTAL  = 8;
  localparam int unsigned ADDR_W = 5;

  logic              clk = 1'b0;
  logic              reset_n_i;
  logic              start_i;
  logic              abort_i;
  logic [31:0]       s_data_i;
  logic              s_valid_i;
  logic              s_last_i;
  logic              s_ready_o;
  logic [31:0]       coeff_o;
  logic [ADDR_W-1:0] coeff_addr_o;
  logic              coeff_en_o;
  logic              busy_o;
  logic              bypass_o;
  logic              done_o;
  logic              error_o;
  logic [31:0]       checksum_o;

  always #5 clk = ~clk;

  mp_coeff_loader #(.M(M), .RESOLUTION(RES)) dut (
    .AXI_clk_i    (clk),
    .reset_n_i    (reset_n_i),
    .start_i      (start_i),
    .abort_i      (abort_i),
    .s_data_i     (s_data_i),
    .s_valid_i    (s_valid_i),
    .s_last_i     (s_last_i),
    .s_ready_o    (s_ready_o),
    .coeff_o      (coeff_o),
    .coeff_addr_o (coeff_addr_o),
    .coeff_en_o   (coeff_en_o),
    .busy_o       (busy_o),
    .bypass_o     (bypass_o),
    .done_o       (done_o),
    .error_o      (error_o),
    .checksum_o   (checksum_o)
  );

  int                n_checks = 0;
  int                n_errors = 0;
  int                cyc = 0;
  logic [31:0]       words [TOTAL];
  logic [ADDR_W+31:0] act_q [$];
  int                en_cyc_q [$];
  int                done_cnt = 0;
  bit                done_en_ok = 1'b0;
  logic [ADDR_W+31:0] exp_e;

  always @(posedge clk) cyc++;

  // Observed BRAM writes and done pulses, sampled mid-cycle.
  always @(negedge clk) begin
    if (coeff_en_o) begin
      act_q.push_back({coeff_addr_o, coeff_o});
      en_cyc_q.push_back(cyc);
    end
    if (done_o) begin
      done_cnt++;
      done_en_ok = coeff_en_o && (coeff_addr_o == ADDR_W'(4 * (TOTAL - 1)));
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not end, required finish");
    $fatal(1);
  end

  // Reference checksum: modulo-2^32 sum of the first n frame words, or 0 without the feature.
  function automatic logic [31:0] exp_sum(input int n);
    logic [31:0] s;
    s = '0;
    for (int i = 0; i < n; i++) s = s + words[i];
`ifndef MP_COEFF_CHECKSUM_EN
    s = '0;
`endif
    return s;
  endfunction

  task automatic clear_obs();
    act_q.delete();
    en_cyc_q.delete();
    done_cnt   = 0;
    done_en_ok = 1'b0;
  endtask

  task automatic fill_random();
    for (int i = 0; i < TOTAL; i++) words[i] = $urandom;
  endtask

  // Issue a start then stream words; mode 0 = valid held, 1 = alternating, 2 = random gaps.
  task automatic drive_frame(input int last_idx, input int abort_idx, input int mode,
                             input int rst_idx, input bit start_mid);
    int  i;
    int  phase;
    int  budget;
    bit  stop;
    bit  v;
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    i = 0; phase = 0; budget = 0; stop = 1'b0;
    while (!stop) begin
      budget++;
      if (budget > 300) begin
        n_checks++; n_errors++;
        $display("FAIL drive_timeout: word %0d never accepted, s_ready_o=%0b required 1", i, s_ready_o);
        stop = 1'b1;
      end else begin
        v = (mode == 0) ? 1'b1 : (mode == 1) ? (phase % 2 == 0) : 1'($urandom_range(0, 1));
        phase++;
        s_valid_i = v;
        s_data_i  = words[i];
        s_last_i  = (i == last_idx);
        abort_i   = v && (i == abort_idx);
        reset_n_i = !(v && (i == rst_idx));
        start_i   = start_mid && (i == 2);
        if (abort_i || !reset_n_i) begin
          stop = 1'b1;
        end else if (v && s_ready_o) begin
          if (i == last_idx || i == TOTAL - 1) stop = 1'b1;
          i++;
        end
        @(negedge clk);
      end
    end
    s_valid_i = 1'b0;
    s_last_i  = 1'b0;
    abort_i   = 1'b0;
    start_i   = 1'b0;
    reset_n_i = 1'b1;
  endtask

  task automatic test_reset();
    reset_n_i = 1'b0; start_i = 1'b0; abort_i = 1'b0;
    s_valid_i = 1'b0; s_last_i = 1'b0; s_data_i = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({s_ready_o, coeff_en_o, busy_o, done_o, error_o, bypass_o} !== 6'b000001) begin
      n_errors++;
      $display("FAIL reset_flags: rdy/en/busy/done/err/byp=%b required 000001",
               {s_ready_o, coeff_en_o, busy_o, done_o, error_o, bypass_o});
    end
    n_checks++;
    if ({coeff_o, coeff_addr_o, checksum_o} !== '0) begin
      n_errors++;
      $display("FAIL reset_data: coeff=%h addr=%h cks=%h required 0", coeff_o, coeff_addr_o, checksum_o);
    end
    reset_n_i = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (s_ready_o !== 1'b0 || busy_o !== 1'b0) begin
      n_errors++;
      $display("FAIL idle_no_start: ready=%b busy=%b required 0 0", s_ready_o, busy_o);
    end
  endtask

  task automatic test_clean_load();
    for (int i = 0; i < TOTAL; i++) words[i] = 32'h0001_0000 + 32'(i);
    clear_obs();
    drive_frame(TOTAL - 1, -1, 0, -1, 1'b0);
    repeat (3) @(negedge clk);
    n_checks++;
    if (act_q.size() != TOTAL) begin
      n_errors++;
      $display("FAIL clean_count: writes=%0d required %0d", act_q.size(), TOTAL);
    end
    for (int k = 0; k < act_q.size() && k < TOTAL; k++) begin
      exp_e = {ADDR_W'(4 * k), words[k]};
      n_checks++;
      if (act_q[k] !== exp_e) begin
        n_errors++;
        $display("FAIL clean_write%0d: got %h required %h", k, act_q[k], exp_e);
      end
    end
    n_checks++;
    if (en_cyc_q.size() == TOTAL && en_cyc_q[TOTAL-1] - en_cyc_q[0] != TOTAL - 1) begin
      n_errors++;
      $display("FAIL clean_rate: span=%0d cycles required %0d", en_cyc_q[TOTAL-1] - en_cyc_q[0], TOTAL - 1);
    end
    n_checks++;
    if (done_cnt != 1 || !done_en_ok) begin
      n_errors++;
      $display("FAIL clean_done: pulses=%0d with_last_write=%0b required 1 1", done_cnt, done_en_ok);
    end
    n_checks++;
    if ({bypass_o, error_o, busy_o, s_ready_o} !== 4'b0000) begin
      n_errors++;
      $display("FAIL clean_status: byp/err/busy/rdy=%b required 0000", {bypass_o, error_o, busy_o, s_ready_o});
    end
    n_checks++;
    if (checksum_o !== exp_sum(TOTAL)) begin
      n_errors++;
      $display("FAIL clean_checksum: got %h required %h", checksum_o, exp_sum(TOTAL));
    end
  endtask

  task automatic test_throttled();
    fill_random();
    clear_obs();
    drive_frame(TOTAL - 1, -1, 1, -1, 1'b1);
    repeat (3) @(negedge clk);
    n_checks++;
    if (act_q.size() != TOTAL) begin
      n_errors++;
      $display("FAIL thr_count: writes=%0d required %0d", act_q.size(), TOTAL);
    end
    for (int k = 0; k < act_q.size() && k < TOTAL; k++) begin
      exp_e = {ADDR_W'(4 * k), words[k]};
      n_checks++;
      if (act_q[k] !== exp_e) begin
        n_errors++;
        $display("FAIL thr_write%0d: got %h required %h", k, act_q[k], exp_e);
      end
    end
    n_checks++;
    if (done_cnt != 1 || !done_en_ok || error_o !== 1'b0) begin
      n_errors++;
      $display("FAIL thr_done: pulses=%0d with_last=%0b err=%b required 1 1 0", done_cnt, done_en_ok, error_o);
    end
    n_checks++;
    if (checksum_o !== exp_sum(TOTAL)) begin
      n_errors++;
      $display("FAIL thr_checksum: got %h required %h", checksum_o, exp_sum(TOTAL));
    end
  endtask

  task automatic test_early_last();
    fill_random();
    clear_obs();
    drive_frame(3, -1, 0, -1, 1'b0);
    repeat (3) @(negedge clk);
    n_checks++;
    if (act_q.size() != 4) begin
      n_errors++;
      $display("FAIL early_count: writes=%0d required 4", act_q.size());
    end
    for (int k = 0; k < act_q.size() && k < 4; k++) begin
      exp_e = {ADDR_W'(4 * k), words[k]};
      n_checks++;
      if (act_q[k] !== exp_e) begin
        n_errors++;
        $display("FAIL early_write%0d: got %h required %h", k, act_q[k], exp_e);
      end
    end
    n_checks++;
    if ({error_o, bypass_o, s_ready_o, busy_o} !== 4'b1100 || done_cnt != 0) begin
      n_errors++;
      $display("FAIL early_status: err/byp/rdy/busy=%b done=%0d required 1100 0",
               {error_o, bypass_o, s_ready_o, busy_o}, done_cnt);
    end
    n_checks++;
    if (checksum_o !== exp_sum(4)) begin
      n_errors++;
      $display("FAIL early_checksum: got %h required %h", checksum_o, exp_sum(4));
    end
  endtask

  task automatic test_missing_last();
    fill_random();
    clear_obs();
    drive_frame(-1, -1, 2, -1, 1'b0);
    repeat (3) @(negedge clk);
    n_checks++;
    if (act_q.size() != TOTAL) begin
      n_errors++;
      $display("FAIL miss_count: writes=%0d required %0d", act_q.size(), TOTAL);
    end
    for (int k = 0; k < act_q.size() && k < TOTAL; k++) begin
      exp_e = {ADDR_W'(4 * k), words[k]};
      n_checks++;
      if (act_q[k] !== exp_e) begin
        n_errors++;
        $display("FAIL miss_write%0d: got %h required %h", k, act_q[k], exp_e);
      end
    end
    n_checks++;
    if (error_o !== 1'b1 || done_cnt != 0 || bypass_o !== 1'b1) begin
      n_errors++;
      $display("FAIL miss_status: err=%b done=%0d byp=%b required 1 0 1", error_o, done_cnt, bypass_o);
    end
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    n_checks++;
    if ({error_o, bypass_o, busy_o, s_ready_o} !== 4'b0111 || checksum_o !== 32'h0) begin
      n_errors++;
      $display("FAIL restart_clears: err/byp/busy/rdy=%b cks=%h required 0111 0",
               {error_o, bypass_o, busy_o, s_ready_o}, checksum_o);
    end
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_abort();
    fill_random();
    clear_obs();
    drive_frame(TOTAL - 1, 5, 0, -1, 1'b0);
    n_checks++;
    if ({busy_o, s_ready_o, error_o, bypass_o} !== 4'b0011) begin
      n_errors++;
      $display("FAIL abort_idle: busy/rdy/err/byp=%b required 0011", {busy_o, s_ready_o, error_o, bypass_o});
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (act_q.size() != 5 || done_cnt != 0) begin
      n_errors++;
      $display("FAIL abort_count: writes=%0d done=%0d required 5 0", act_q.size(), done_cnt);
    end
    for (int k = 0; k < act_q.size() && k < 5; k++) begin
      exp_e = {ADDR_W'(4 * k), words[k]};
      n_checks++;
      if (act_q[k] !== exp_e) begin
        n_errors++;
        $display("FAIL abort_write%0d: got %h required %h", k, act_q[k], exp_e);
      end
    end
    n_checks++;
    if (checksum_o !== exp_sum(5)) begin
      n_errors++;
      $display("FAIL abort_checksum: got %h required %h", checksum_o, exp_sum(5));
    end
  endtask

  task automatic test_reset_midload();
    fill_random();
    clear_obs();
    drive_frame(TOTAL - 1, -1, 0, 4, 1'b0);
    n_checks++;
    if ({s_ready_o, coeff_en_o, busy_o, done_o, error_o, bypass_o} !== 6'b000001 ||
        {coeff_o, coeff_addr_o, checksum_o} !== '0) begin
      n_errors++;
      $display("FAIL midrst_outputs: flags=%b coeff=%h addr=%h cks=%h required 000001 0 0 0",
               {s_ready_o, coeff_en_o, busy_o, done_o, error_o, bypass_o}, coeff_o, coeff_addr_o, checksum_o);
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if (act_q.size() != 4) begin
      n_errors++;
      $display("FAIL midrst_count: writes=%0d required 4", act_q.size());
    end
    fill_random();
    clear_obs();
    drive_frame(TOTAL - 1, -1, 2, -1, 1'b0);
    repeat (3) @(negedge clk);
    n_checks++;
    if (act_q.size() != TOTAL || done_cnt != 1) begin
      n_errors++;
      $display("FAIL midrst_reload: writes=%0d done=%0d required %0d 1", act_q.size(), done_cnt, TOTAL);
    end
    for (int k = 0; k < act_q.size() && k < TOTAL; k++) begin
      exp_e = {ADDR_W'(4 * k), words[k]};
      n_checks++;
      if (act_q[k] !== exp_e) begin
        n_errors++;
        $display("FAIL midrst_write%0d: got %h required %h", k, act_q[k], exp_e);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 3; f++) begin
      fill_random();
      clear_obs();
      drive_frame(TOTAL - 1, -1, 2, -1, 1'b0);
      repeat (2) @(negedge clk);
      n_checks++;
      if (act_q.size() != TOTAL || done_cnt != 1 || bypass_o !== 1'b0 || error_o !== 1'b0) begin
        n_errors++;
        $display("FAIL b2b%0d_status: writes=%0d done=%0d byp=%b err=%b required %0d 1 0 0",
                 f, act_q.size(), done_cnt, bypass_o, error_o, TOTAL);
      end
      for (int k = 0; k < act_q.size() && k < TOTAL; k++) begin
        exp_e = {ADDR_W'(4 * k), words[k]};
        n_checks++;
        if (act_q[k] !== exp_e) begin
          n_errors++;
          $display("FAIL b2b%0d_write%0d: got %h required %h", f, k, act_q[k], exp_e);
        end
      end
      n_checks++;
      if (checksum_o !== exp_sum(TOTAL)) begin
        n_errors++;
        $display("FAIL b2b%0d_checksum: got %h required %h", f, checksum_o, exp_sum(TOTAL));
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_load();
    test_throttled();
    test_early_last();
    test_missing_last();
    test_abort();
    test_reset_midload();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
